axi_issue_arbiter: RTL and testbench
====================================

# axi_issue_arbiter

Per-master-interface request arbiter and issue limiter for the AXI crossbar address path. It shares one master-side AW or AR channel among PORTS slave-interface requesters. Arbitration is round-robin, with optional QoS priority. It counts outstanding transactions and withholds new grants once ISSUE_LIMIT transactions are in flight. There is one instance per master interface per direction, between the slave-side address decode and the master-side address register slice.

## Interface

Parameters:
- PORTS, 4, number of requesters (≥1)
- ISSUE_LIMIT, 4, maximum outstanding transactions (≥1)
- QOS_ENABLE, 1, 1 = highest req_qos wins before round-robin; 0 = pure round-robin
- CNT_WIDTH, $clog2(ISSUE_LIMIT+1), width of outstanding counter
- SEL_WIDTH, (PORTS>1 ? $clog2(PORTS) : 1), width of encoded grant

Ports:
- clk  input  1  clock, all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- req  input  PORTS  request per requester; must stay high until granted and accepted
- req_qos  input  PORTS*4  QoS per requester, field i at [4*i+3:4*i]
- grant  output  PORTS  one-hot grant, registered
- grant_valid  output  1  grant is active (OR of grant)
- grant_encoded  output  SEL_WIDTH  index of granted requester
- accept  input  1  address handshake completed on master side for current grant
- complete  input  1  one outstanding transaction retired (last B / last R beat)
- outstanding  output  CNT_WIDTH  current outstanding count
- full  output  1  outstanding == ISSUE_LIMIT

## Operation

- Two states: IDLE (grant_valid=0) and GRANTED (grant_valid=1).
- IDLE → GRANTED when |req and !full at a clock edge. The winner is registered into grant/grant_encoded at that edge.
- Winner selection (combinational, from the current req):
  - QOS_ENABLE=1: candidates are the requesting ports whose req_qos equals the maximum req_qos among requesting ports.
  - QOS_ENABLE=0: all requesting ports are candidates.
  - The winner is the first candidate scanning upward from last_ptr+1, wrapping modulo PORTS.
- GRANTED: grant, grant_encoded and grant_valid are held unchanged until accept=1.
  - Dropping req or changing qos does not alter or revoke the grant.
- accept while GRANTED:
  - last_ptr <= grant_encoded.
  - Next state is IDLE, so there is exactly one idle cycle between grants.
- accept while IDLE is ignored: no count change, no pointer change.
- Counter, per clock edge:
  - +1 if accept && grant_valid.
  - −1 if complete && outstanding != 0.
  - Both at once: unchanged.
  - complete at 0: ignored, stays 0, no underflow.
- The counter never exceeds ISSUE_LIMIT, because grants are issued only when !full.
- full is combinational from the counter.
  - A grant already active when full rises stays active. This cannot occur by construction, but the bench must check it.
- Reset values (asynchronous, immediate on rst=1):
  - grant=0, grant_valid=0, grant_encoded=0, outstanding=0, full=0, state=IDLE.
  - last_ptr=PORTS−1, so port 0 is favoured first.
- Reset asserted mid-grant or with transactions outstanding discards everything. No grant is issued while rst=1.

## Timing

- Arbitration latency: req rising in cycle N (IDLE, !full) → grant high from edge N+1.
- Grant lifetime: from grant edge until the edge sampling accept=1. Deasserted at that edge.
- Minimum grant period is 2 cycles: GRANTED with accept=1 immediately, then 1 idle cycle.
- outstanding updates at the same edge that samples accept/complete. full follows in the same cycle.
- With full=1 and req high, a complete in cycle N clears full after edge N. The grant appears at edge N+1 at the earliest.
- PORTS=1: grant_encoded is constant 0. Otherwise behaviour is identical.

## Test plan

- Round-robin, PORTS=4, QOS_ENABLE=0, req=4'b1111 held, accept pulsed each grant, complete each cycle.
  - Required: grant_encoded sequence 0,1,2,3,0.
  - Required: grant_valid pattern 1,0,1,0,…
- QoS priority, QOS_ENABLE=1, req=4'b1011, qos = {port3:2, port1:5, port0:5}.
  - Required: grants alternate 0,1,0,1; port 3 never granted while ports 0/1 request.
  - Drop ports 0/1: port 3 granted next.
- Issue limit, ISSUE_LIMIT=2, no complete, requests continuous.
  - Required: two grants accepted, outstanding=2, full=1, grant_valid stays 0.
  - One complete pulse → outstanding=1, full=0, next grant one cycle later.
- Simultaneous events: accept and complete in the same cycle with outstanding=1 → outstanding stays 1.
  - complete with outstanding=0 → stays 0.
  - accept in IDLE → no change.
- Grant hold: grant to port 2, then req[2] drops and req[0] rises before accept.
  - Required: grant stays 4'b0100 until accept, then port 0 granted after the idle cycle.
- Reset mid-operation: assert rst asynchronously (off clock edge) while GRANTED with outstanding=3.
  - Required: grant=0, outstanding=0, full=0 immediately.
  - After release with req=4'b1111: first grant is port 0.

Source files
------------

// File: rtl/axi_issue_arbiter.sv
// axi_issue_arbiter
// Shares one master-side AW/AR address channel among PORTS requesters.
// Round-robin arbitration with optional QoS pre-selection, plus an
// outstanding-transaction limiter that withholds grants once ISSUE_LIMIT
// transactions are in flight.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant active; arbitrate when a request is present and !full
//   GRANTED | grant registered and held until the master side accepts it
module axi_issue_arbiter #(
  parameter int PORTS       = 4,
  parameter int ISSUE_LIMIT = 4,
  parameter int QOS_ENABLE  = 1,
  parameter int CNT_WIDTH   = $clog2(ISSUE_LIMIT + 1),
  parameter int SEL_WIDTH   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PORTS-1:0]     req,
  input  logic [4*PORTS-1:0]   req_qos,
  output logic [PORTS-1:0]     grant,
  output logic                 grant_valid,
  output logic [SEL_WIDTH-1:0] grant_encoded,
  input  logic                 accept,
  input  logic                 complete,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 full
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [SEL_WIDTH-1:0] last_ptr;
  logic [3:0]           max_qos;
  logic [PORTS-1:0]     cand;
  logic                 win_found;
  logic [SEL_WIDTH-1:0] win_idx;
  logic [PORTS-1:0]     win_onehot;
  logic                 go;
  logic                 take;
  logic                 inc;
  logic                 dec;

  // Candidate set: all requesters, or only those at the highest requesting QoS.
  always_comb begin
    max_qos = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (req[i] && (req_qos[4*i +: 4] > max_qos)) begin
        max_qos = req_qos[4*i +: 4];
      end
    end
    cand = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (QOS_ENABLE != 0) begin
        cand[i] = req[i] && (req_qos[4*i +: 4] == max_qos);
      end else begin
        cand[i] = req[i];
      end
    end
  end

  // Round-robin scan upward from last_ptr+1; the previous winner is checked last.
  always_comb begin
    int                   idx;
    logic [SEL_WIDTH-1:0] sel;
    idx        = 0;
    sel        = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = int'(last_ptr) + k;
      if (idx >= PORTS) begin
        idx = idx - PORTS;
      end
      sel = SEL_WIDTH'(idx);
      if (!win_found && cand[sel]) begin
        win_found       = 1'b1;
        win_idx         = sel;
        win_onehot      = '0;
        win_onehot[sel] = 1'b1;
      end
    end
  end

  assign go   = (state_q == IDLE) && win_found && !full;
  assign take = (state_q == GRANTED) && accept;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: IDLE after every accept guarantees one idle cycle between grants.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go)     state_d = GRANTED;
      GRANTED: if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant registers: loaded on arbitration, frozen while granted, cleared on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= '0;
      grant_encoded <= '0;
    end else if (go) begin
      grant         <= win_onehot;
      grant_encoded <= win_idx;
    end else if (take) begin
      grant         <= '0;
    end
  end

  // Round-robin pointer moves only when a grant is actually consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ptr <= SEL_WIDTH'(PORTS - 1);
    end else if (take) begin
      last_ptr <= grant_encoded;
    end
  end

  assign grant_valid = |grant;
  assign inc         = accept && grant_valid;
  assign dec         = complete && (outstanding != '0);

  // Outstanding counter; simultaneous issue and retire cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (inc && !dec) begin
      outstanding <= outstanding + CNT_WIDTH'(1);
    end else if (dec && !inc) begin
      outstanding <= outstanding - CNT_WIDTH'(1);
    end
  end

  assign full = (outstanding == CNT_WIDTH'(ISSUE_LIMIT));

endmodule

// File: tb/tb_axi_issue_arbiter.sv
// Bench for axi_issue_arbiter: two instances share stimulus, one with QoS and
// ISSUE_LIMIT=4, one pure round-robin with ISSUE_LIMIT=2. Each is compared
// every cycle against a transaction-level reference model.
module tb_axi_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_qos;
  logic        accept;
  logic        complete;

  logic [3:0]  g_q, g_r;
  logic        gv_q, gv_r;
  logic [1:0]  ge_q, ge_r;
  logic [2:0]  out_q;
  logic [1:0]  out_r;
  logic        full_q, full_r;

  always #5 clk = ~clk;

  axi_issue_arbiter #(.PORTS(4), .ISSUE_LIMIT(4), .QOS_ENABLE(1)) u_qos (
    .clk(clk), .rst(rst), .req(req), .req_qos(req_qos),
    .grant(g_q), .grant_valid(gv_q), .grant_encoded(ge_q),
    .accept(accept), .complete(complete), .outstanding(out_q), .full(full_q)
  );

  axi_issue_arbiter #(.PORTS(4), .ISSUE_LIMIT(2), .QOS_ENABLE(0)) u_rr (
    .clk(clk), .rst(rst), .req(req), .req_qos(req_qos),
    .grant(g_r), .grant_valid(gv_r), .grant_encoded(ge_r),
    .accept(accept), .complete(complete), .outstanding(out_r), .full(full_r)
  );

  // gnt = granted port or -1 when idle; last = most recently accepted port.
  typedef struct {
    int gnt;
    int outst;
    int last;
  } mdl_t;

  mdl_t mq, mr;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.gnt   = -1;
    m.outst = 0;
    m.last  = 3;
    return m;
  endfunction

  function automatic int pick(input logic [3:0] r, input logic [15:0] q,
                              input bit qen, input int last);
    int mx;
    int i;
    mx = -1;
    for (int p = 0; p < 4; p++)
      if (r[p] && int'(q[4*p +: 4]) > mx) mx = int'(q[4*p +: 4]);
    for (int k = 1; k <= 4; k++) begin
      i = (last + k) % 4;
      if (r[i] && (!qen || int'(q[4*i +: 4]) == mx)) return i;
    end
    return -1;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int limit, input bit qen,
                                input logic [3:0] r, input logic [15:0] q,
                                input bit acc, input bit cmp);
    mdl_t n;
    int   d;
    n = m;
    d = 0;
    if (acc && m.gnt >= 0) d = d + 1;
    if (cmp && m.outst > 0) d = d - 1;
    n.outst = m.outst + d;
    if (m.gnt >= 0) begin
      if (acc) begin
        n.last = m.gnt;
        n.gnt  = -1;
      end
    end else if (m.outst < limit) begin
      n.gnt = pick(r, q, qen, m.last);
    end
    return n;
  endfunction

  task automatic check_dut(input string nm, input mdl_t m, input int limit,
                           input int g, input int gv, input int ge,
                           input int o, input int f);
    chk({nm, ".grant"}, g, (m.gnt < 0) ? 0 : (1 << m.gnt));
    chk({nm, ".grant_valid"}, gv, (m.gnt >= 0) ? 1 : 0);
    if (m.gnt >= 0) chk({nm, ".grant_encoded"}, ge, m.gnt);
    chk({nm, ".outstanding"}, o, m.outst);
    chk({nm, ".full"}, f, (m.outst == limit) ? 1 : 0);
  endtask

  task automatic check_all();
    check_dut("qos", mq, 4, int'(g_q), int'(gv_q), int'(ge_q), int'(out_q), int'(full_q));
    check_dut("rr",  mr, 2, int'(g_r), int'(gv_r), int'(ge_r), int'(out_r), int'(full_r));
  endtask

  task automatic cycle(input logic r_rst, input logic [3:0] r, input logic [15:0] q,
                       input bit acc, input bit cmp);
    mdl_t nq, nr;
    @(negedge clk);
    rst      = r_rst;
    req      = r;
    req_qos  = q;
    accept   = acc;
    complete = cmp;
    if (r_rst) begin
      nq = mdl_reset();
      nr = mdl_reset();
    end else begin
      nq = step(mq, 4, 1'b1, r, q, acc, cmp);
      nr = step(mr, 2, 1'b0, r, q, acc, cmp);
    end
    @(posedge clk);
    #1;
    mq = nq;
    mr = nr;
    check_all();
  endtask

  task automatic sync_reset();
    cycle(1'b1, 4'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_rr[5];
    int exp_qos[4];
    int k;
    logic [15:0] rq;

    exp_rr  = '{0, 1, 2, 3, 0};
    exp_qos = '{0, 1, 0, 1};
    rst = 1'b1; req = '0; req_qos = '0; accept = 1'b0; complete = 1'b0;
    mq = mdl_reset();
    mr = mdl_reset();
    #2;
    chk("reset.grant", int'(g_q), 0);
    chk("reset.grant_valid", int'(gv_q), 0);
    chk("reset.grant_encoded", int'(ge_q), 0);
    chk("reset.outstanding", int'(out_q), 0);
    chk("reset.full", int'(full_q), 0);
    sync_reset();

    // Round-robin with every port requesting, equal QoS.
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 4'hF, 16'h0, 1'b1, 1'b1);
      chk("rr.valid_pattern", int'(gv_r), i % 2);
      if (i % 2 == 1) begin
        chk("rr.sequence", int'(ge_r), exp_rr[k]);
        chk("rr.sequence_qos_equal", int'(ge_q), exp_rr[k]);
        k++;
      end
    end

    // QoS priority: ports 0/1 at 5 beat port 3 at 2.
    sync_reset();
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 4'b1011, 16'h2055, 1'b1, 1'b1);
      if (i % 2 == 1) begin
        chk("qos.sequence", int'(ge_q), exp_qos[k]);
        k++;
      end
    end
    cycle(1'b0, 4'b1000, 16'h2055, 1'b1, 1'b1);
    chk("qos.low_prio_after_drop", int'(ge_q), 3);
    chk("qos.low_prio_valid", int'(gv_q), 1);

    // Issue limit on the ISSUE_LIMIT=2 instance.
    sync_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'hF, 16'h0, 1'b1, 1'b0);
    chk("limit.outstanding", int'(out_r), 2);
    chk("limit.full", int'(full_r), 1);
    chk("limit.no_grant", int'(gv_r), 0);
    cycle(1'b0, 4'hF, 16'h0, 1'b0, 1'b1);
    chk("limit.after_complete_out", int'(out_r), 1);
    chk("limit.after_complete_full", int'(full_r), 0);
    chk("limit.after_complete_nogrant", int'(gv_r), 0);
    cycle(1'b0, 4'hF, 16'h0, 1'b0, 1'b0);
    chk("limit.regrant", int'(gv_r), 1);

    // Simultaneous accept/complete, complete at zero, accept in IDLE.
    cycle(1'b0, 4'hF, 16'h0, 1'b1, 1'b1);
    chk("simul.acc_cmp_out", int'(out_r), 1);
    cycle(1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    chk("simul.cmp_out", int'(out_r), 0);
    cycle(1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    chk("simul.cmp_at_zero", int'(out_r), 0);
    cycle(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
    chk("simul.acc_idle_out", int'(out_r), 0);
    chk("simul.acc_idle_valid", int'(gv_r), 0);
    cycle(1'b0, 4'hF, 16'h0, 1'b0, 1'b0);
    chk("simul.ptr_unchanged", int'(ge_r), 3);

    // Grant hold while requests change underneath.
    sync_reset();
    cycle(1'b0, 4'b0100, 16'h0, 1'b0, 1'b0);
    chk("hold.initial", int'(g_q), 4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b0001, 16'hF000, 1'b0, 1'b0);
      chk("hold.held", int'(g_q), 4);
    end
    cycle(1'b0, 4'b0001, 16'h0, 1'b1, 1'b0);
    chk("hold.released", int'(gv_q), 0);
    cycle(1'b0, 4'b0001, 16'h0, 1'b0, 1'b0);
    chk("hold.next_port0", int'(g_q), 1);

    // Asynchronous reset while GRANTED with three outstanding.
    sync_reset();
    for (int i = 0; i < 7; i++) cycle(1'b0, 4'hF, 16'h0, 1'b1, 1'b0);
    chk("arst.pre_out", int'(out_q), 3);
    chk("arst.pre_valid", int'(gv_q), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    mq = mdl_reset();
    mr = mdl_reset();
    chk("arst.grant", int'(g_q), 0);
    chk("arst.outstanding", int'(out_q), 0);
    chk("arst.full", int'(full_q), 0);
    chk("arst.rr_grant", int'(g_r), 0);
    cycle(1'b1, 4'hF, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'hF, 16'h0, 1'b0, 1'b0);
    chk("arst.first_port0", int'(ge_q), 0);
    chk("arst.first_valid", int'(gv_q), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rq = '0;
      for (int p = 0; p < 4; p++) rq[4*p +: 4] = 4'($urandom_range(0, 3));
      cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)), rq,
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
